// File: rtl/varredura_matriz_pkg.sv
// Shared constants, FSM state encoding and column helper for the 7x7 matrix scanner.
package varredura_matriz_pkg;

    localparam int NUM_COL = 7;
    localparam int NUM_ROW = 7;
    localparam int COL_W   = 3;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } estado_t;

    // Column sequence 0..6 then back to 0; code 7 is never produced.
    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] col);
        return (col == COL_W'(NUM_COL - 1)) ? '0 : col + 1'b1;
    endfunction

endpackage

// File: rtl/varredura_matriz_if.sv
// Host-side frame-buffer write / commit handshake of the matrix scanner.
interface varredura_matriz_if;
    import varredura_matriz_pkg::*;

    logic                 load;
    logic [COL_W-1:0]     load_col;
    logic [NUM_ROW-1:0]   load_data;
    logic                 commit;
    logic                 ready;

    modport master (output load, load_col, load_data, commit, input ready);
    modport slave  (input load, load_col, load_data, commit, output ready);

endinterface

// File: rtl/divisor_varredura.sv
// Column dwell timer: BLANK cycles blanked, then PRESC-BLANK cycles shown, repeating.
module divisor_varredura
    import varredura_matriz_pkg::*;
#(
    parameter int PRESC = 1000,
    parameter int BLANK = 2
)
(
    input  logic    clk,
    input  logic    reset,
    output estado_t state_next,
    output logic    blank_end,
    output logic    dwell_end
);

    localparam int CNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    estado_t          state_reg;

    // BLANK >= 1 and PRESC > BLANK, so the two strobes never coincide.
    assign blank_end = (cnt_reg == CNT_W'(BLANK - 1));
    assign dwell_end = (cnt_reg == CNT_W'(PRESC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        if (dwell_end) begin
            cnt_next   = '0;
            state_next = ST_BLANK;
        end else if (blank_end) begin
            state_next = ST_SHOW;
        end
    end

endmodule

// File: rtl/varredura_matriz.sv
// 7x7 LED matrix column scanner with double-buffered frame memory and load/commit handshake.
module varredura_matriz
    import varredura_matriz_pkg::*;
#(
    parameter int PRESC = 1000,
    parameter int BLANK = 2
)
(
    input  logic                clk,
    input  logic                reset,
    varredura_matriz_if.slave   bus,
    output logic                sel1,
    output logic                sel2,
    output logic                sel3,
    output logic                enable,
    output logic [NUM_ROW-1:0]  rows,
    output logic                frame_tick
);

    estado_t state_next;
    logic    blank_end;
    logic    dwell_end;

    divisor_varredura #(
        .PRESC (PRESC),
        .BLANK (BLANK)
    ) u_divisor (
        .clk        (clk),
        .reset      (reset),
        .state_next (state_next),
        .blank_end  (blank_end),
        .dwell_end  (dwell_end)
    );

    logic [COL_W-1:0]                 col_reg;
    logic [COL_W-1:0]                 col_next;
    logic                             pending_reg;
    logic                             ready;
    logic                             load_ok;
    logic                             commit_ok;
    logic                             last_col;
    logic                             swap;
    logic [NUM_COL-1:0][NUM_ROW-1:0]  shadow;
    logic [NUM_COL-1:0][NUM_ROW-1:0]  active;

    logic [COL_W-1:0]                 sel_reg;
    logic                             enable_reg;
    logic [NUM_ROW-1:0]               rows_reg;
    logic                             frame_tick_reg;

    assign ready     = !pending_reg && !reset;
    assign bus.ready = ready;
    assign load_ok   = bus.load && ready && (bus.load_col < COL_W'(NUM_COL));
    assign commit_ok = bus.commit && ready;
    assign last_col  = (col_reg == COL_W'(NUM_COL - 1));
    // Swap on the final SHOW cycle of the last column so the new frame starts clean at column 0.
    assign swap      = pending_reg && dwell_end && last_col;
    assign col_next  = dwell_end ? next_col(col_reg) : col_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            col_reg <= col_next;
            if (swap) begin
                pending_reg <= 1'b0;
            end else if (commit_ok) begin
                pending_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_col
            logic [NUM_ROW-1:0] shadow_reg;
            logic [NUM_ROW-1:0] active_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (load_ok && (bus.load_col == COL_W'(gi))) begin
                        shadow_reg <= bus.load_data;
                    end
                    if (swap) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            assign shadow[gi] = shadow_reg;
            assign active[gi] = active_reg;
        end
    endgenerate

    // Outputs are registered from next-state values so they line up with the current dwell phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_reg        <= '0;
            enable_reg     <= 1'b0;
            rows_reg       <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            sel_reg        <= col_next;
            enable_reg     <= (state_next == ST_SHOW);
            rows_reg       <= (state_next == ST_SHOW) ? active[col_next] : '0;
            frame_tick_reg <= dwell_end && last_col;
        end
    end

    assign {sel1, sel2, sel3} = sel_reg;
    assign enable             = enable_reg;
    assign rows               = rows_reg;
    assign frame_tick         = frame_tick_reg;

endmodule

// File: doc/varredura_matriz.md
VARREDURA_MATRIZ -- requirements
Module: varredura_matriz

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; parameters and ports follow, one per line.
REQ-002 Parameter PRESC, default 1000: clock cycles per column dwell; legal range PRESC > BLANK.
REQ-003 Parameter BLANK, default 2: leading cycles of each dwell with enable low; legal range BLANK >= 1.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 load  in  1  write strobe into the shadow frame buffer.
REQ-007 load_col  in  3  column index for load; legal values 0..6.
REQ-008 load_data  in  7  row pattern for load_col; bit i = row i lit.
REQ-009 commit  in  1  request to swap the shadow buffer into the active buffer.
REQ-010 ready  out  1  high = load and commit accepted this cycle.
REQ-011 sel1, sel2, sel3  out  1 each  column code to the 3-to-7 column decoder; sel1 is the MSB.
REQ-012 enable  out  1  column-decoder enable, active-high.
REQ-013 rows  out  7  row drive, active-high.
REQ-014 frame_tick  out  1  one-cycle pulse at frame wrap.

Function
REQ-015 Scan order SHALL be column 0..6 and wrap 6->0; codes 7 (sel=111) SHALL never be driven.
REQ-016 Each column dwell SHALL last exactly PRESC cycles: state BLANK for BLANK cycles, then state SHOW for PRESC-BLANK cycles.
REQ-017 In BLANK: enable=0 and rows=0, with {sel1,sel2,sel3} already at the new column code.
REQ-018 In SHOW: enable=1 and rows=active[col].
REQ-019 Transitions: BLANK->SHOW after BLANK cycles; SHOW->BLANK with col+1 (mod 7) after PRESC-BLANK cycles.
REQ-020 All outputs SHALL be registered; the sel code SHALL never change while enable=1.
REQ-021 frame_tick SHALL be 1 for exactly the first BLANK cycle of column 0 following a 6->0 wrap; it SHALL NOT pulse after reset.
REQ-022 When load=1, ready=1 and load_col<=6: shadow[load_col] <= load_data on that edge.
REQ-023 Loads with load_col=7, or with ready=0, SHALL be ignored with no state change.
REQ-024 commit=1 with ready=1 SHALL set pending; ready SHALL be 0 while pending.
REQ-025 The swap (active <= shadow, pending cleared) SHALL occur on the last SHOW cycle of column 6; the new pattern is visible from column 0 of the next frame.
REQ-026 ready SHALL return to 1 on the cycle after the swap.
REQ-027 load and commit in the same cycle SHALL include that load in the committed frame.
REQ-028 The shadow buffer SHALL be retained after a swap; no auto-clear.

Reset
REQ-029 reset SHALL take priority over all inputs and act on the next edge, including mid-dwell and mid-frame.
REQ-030 Reset values SHALL be:
- state=BLANK, col=0, dwell counter=0
- sel=000, enable=0, rows=0, frame_tick=0
- active and shadow buffers all 0, pending=0
- ready=0 while reset is high; ready=1 on the first cycle after release
REQ-031 The first BLANK cycle SHALL be the first cycle after reset deasserts.

Structure
REQ-032 NUM_COL=7, NUM_ROW=7 and the state encodings (BLANK, SHOW) SHALL live in the shared constants include file.
REQ-033 The dwell counter and BLANK/SHOW timing SHALL be one sub-module, divisor_varredura, emitting blank_end and dwell_end strobes.
REQ-034 The frame buffers and handshake SHALL be in the top module.

Verification
REQ-035 The bench SHALL cover the following directed scenarios, all with PRESC=10 and BLANK=2:
- Reset release, empty buffer -> sel steps 000,001,...,110,000 every 10 cycles; enable is 0 for 2 cycles and 1 for 8; rows=0; frame_tick pulses once per 70 cycles, starting at cycle 70.
- load col3=7'h55, then commit -> ready falls; from the next frame column 0, rows=7'h55 only while sel=011 and enable=1.
- load and commit in the same cycle, col6=7'h7F -> pattern is shown in the next frame at sel=110; ready=0 until the cycle after the swap.
- load with load_col=7, and a second commit while pending -> both ignored; buffers and pending unchanged.
- reset asserted mid-SHOW of column 4 -> next edge gives sel=000, enable=0, rows=0; previously committed pattern is cleared.
- Continuous check on every cycle -> no sel change while enable=1; sel=111 never driven.
